// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// IF->ID pipeline register with a valid/ready handshake, a decode-side stall,
// a flush, and a two-entry skid buffer. The main entry drives decode
// directly. The skid entry catches one beat that fetch launched while decode
// was holding. Because in_ready is a register, there is no combinational path
// from decode back to fetch.
//
// Optional feature macro: IF_ID_STAGE_STAT_EN
//   When this macro is defined, the stage adds two saturating statistics
//   counters, stall_cnt and flush_cnt. Only rst clears them.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   in_valid   in   1       fetch offers {in_pc, in_inst}
//   in_ready   out  1       stage can accept (registered)
//   in_pc      in   PC_W    fetch address
//   in_inst    in   INST_W  fetched instruction
//   stall      in   1       decode hazard hold, same effect as out_ready=0
//   flush      in   1       kill every held entry
//   out_valid  out  1       {out_pc, out_inst} valid for decode
//   out_ready  in   1       decode consumes
//   out_pc     out  PC_W    decode-stage address
//   out_inst   out  INST_W  decode-stage instruction (NOP_INST when invalid)
//   stall_cnt  out  32      [IF_ID_STAGE_STAT_EN] cycles stalled with valid data
//   flush_cnt  out  16      [IF_ID_STAGE_STAT_EN] flush cycles
//
// State table
//   state    | meaning
//   ST_EMPTY | main entry invalid, skid entry invalid
//   ST_FULL  | main entry valid, skid entry empty
//   ST_SKID  | main and skid entries both valid, in_ready low
// ---------------------------------------------------------------------------
module if_id_stage #(
   parameter int                PC_W     = 32,
   parameter int                INST_W   = 32,
   parameter logic [INST_W-1:0] NOP_INST = '0,
   parameter logic [PC_W-1:0]   RST_PC   = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst
`ifdef IF_ID_STAGE_STAT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [15:0]       flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t              state;
   logic [PC_W-1:0]     main_pc;
   logic [INST_W-1:0]   main_inst;
   logic [PC_W-1:0]     skid_pc;
   logic [INST_W-1:0]   skid_inst;

   logic                acc;
   logic                dr;
   logic                cons;

   assign acc  = in_valid & in_ready;
   assign dr   = out_ready & ~stall;
   assign cons = out_valid & dr;

   // main_pc also serves as the out_pc register. It keeps the last delivered
   // address after the stage drains, and returns to RST_PC on rst or flush.
   assign out_pc   = main_pc;
   assign out_inst = out_valid ? main_inst : NOP_INST;

   // The data registers have no reset. They are written only on an accept or
   // on a skid->main move. out_valid masks whatever is left in them.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= ST_EMPTY;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         main_pc   <= RST_PC;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  main_pc   <= in_pc;
                  main_inst <= in_inst;
                  state     <= ST_FULL;
                  out_valid <= 1'b1;
                  in_ready  <= 1'b1;
               end
            end
            ST_FULL: begin
               if (acc && cons) begin
                  main_pc   <= in_pc;
                  main_inst <= in_inst;
               end else if (cons) begin
                  state     <= ST_EMPTY;
                  out_valid <= 1'b0;
               end else if (acc) begin
                  skid_pc   <= in_pc;
                  skid_inst <= in_inst;
                  state     <= ST_SKID;
                  in_ready  <= 1'b0;
               end
            end
            ST_SKID: begin
               // in_ready is low in this state, so fetch cannot be accepted here.
               if (cons) begin
                  main_pc   <= skid_pc;
                  main_inst <= skid_inst;
                  state     <= ST_FULL;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_EMPTY;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               main_pc   <= RST_PC;
            end
         endcase
      end
   end

`ifdef IF_ID_STAGE_STAT_EN
   // A flush does not clear these counters. They saturate at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && out_valid && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

   localparam logic [31:0] NOP    = 32'h0000_0000;
   localparam logic [31:0] RSTPC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst, in_valid, stall, flush, out_ready;
   logic [31:0] in_pc, in_inst;
   logic        in_ready, out_valid;
   logic [31:0] out_pc, out_inst;
`ifdef IF_ID_STAGE_STAT_EN
   logic [31:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_id_stage #(
      .PC_W(32), .INST_W(32), .NOP_INST(NOP), .RST_PC(RSTPC)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .stall(stall), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_inst(out_inst)
`ifdef IF_ID_STAGE_STAT_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   // Reference model: a FIFO of up to two beats, plus the last address shown.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } beat_t;

   beat_t       mq[$];
   logic [31:0] m_last_pc = RSTPC;
   longint      m_stall_cnt = 0;
   longint      m_flush_cnt = 0;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drives one cycle of inputs, lets the clock edge pass, then advances the model.
   task automatic step(input bit r, input bit iv, input logic [31:0] pc,
                       input logic [31:0] inst, input bit st, input bit fl, input bit ordy);
      bit    m_rdy, m_vld, acc, cons;
      beat_t b;
      rst = r; in_valid = iv; in_pc = pc; in_inst = inst;
      stall = st; flush = fl; out_ready = ordy;
      m_rdy = (mq.size() < 2);
      m_vld = (mq.size() > 0);
      acc   = iv && m_rdy;
      cons  = m_vld && ordy && !st;
      @(posedge clk);
      #1;
      if (r) begin
         mq.delete();
         m_last_pc   = RSTPC;
         m_stall_cnt = 0;
         m_flush_cnt = 0;
      end else begin
         if (st && m_vld && !fl && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
         if (fl && m_flush_cnt < 64'hFFFF) m_flush_cnt++;
         if (fl) begin
            mq.delete();
            m_last_pc = RSTPC;
         end else begin
            if (cons) void'(mq.pop_front());
            if (acc) begin
               b.pc = pc; b.inst = inst;
               mq.push_back(b);
            end
            if (mq.size() > 0) m_last_pc = mq[0].pc;
         end
      end
   endtask

   task automatic check_model(input string tag);
      cmp({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
      cmp({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < 2));
      cmp({tag, ".out_pc"},    64'(out_pc),    64'(m_last_pc));
      cmp({tag, ".out_inst"},  64'(out_inst),  64'((mq.size() > 0) ? mq[0].inst : NOP));
`ifdef IF_ID_STAGE_STAT_EN
      cmp({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(m_stall_cnt));
      cmp({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(m_flush_cnt));
`endif
   endtask

   typedef struct {
      bit          r, iv, st, fl, ordy;
      logic [31:0] pc, inst;
      bit          e_valid, e_ready;
      logic [31:0] e_pc, e_inst;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit r, bit iv, logic [31:0] pc, logic [31:0] inst,
                               bit st, bit fl, bit ordy,
                               bit ev, bit er, logic [31:0] epc, logic [31:0] einst);
      vec_t v;
      v.r = r; v.iv = iv; v.pc = pc; v.inst = inst; v.st = st; v.fl = fl; v.ordy = ordy;
      v.e_valid = ev; v.e_ready = er; v.e_pc = epc; v.e_inst = einst;
      return v;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
      stall = 1'b0; flush = 1'b0; out_ready = 1'b0;

      //            r iv pc        inst          st fl or   v r  pc        inst
      // T1: reset
      vt.push_back(mk(1,0,32'h00,32'h0,        0,0,0,   0,1,32'h00,NOP));
      vt.push_back(mk(1,0,32'h00,32'h0,        0,0,0,   0,1,32'h00,NOP));
      vt.push_back(mk(0,0,32'h00,32'h0,        0,0,0,   0,1,32'h00,NOP));
      // T2: streaming A, B, C
      vt.push_back(mk(0,1,32'h00,32'hA0000001, 0,0,1,   1,1,32'h00,32'hA0000001));
      vt.push_back(mk(0,1,32'h04,32'hB0000002, 0,0,1,   1,1,32'h04,32'hB0000002));
      vt.push_back(mk(0,1,32'h08,32'hC0000003, 0,0,1,   1,1,32'h08,32'hC0000003));
      vt.push_back(mk(0,0,32'h00,32'h0,        0,0,1,   0,1,32'h08,NOP));
      // T3: stall fills skid, then drain in order
      vt.push_back(mk(0,1,32'h10,32'hA1000010, 0,0,1,   1,1,32'h10,32'hA1000010));
      vt.push_back(mk(0,1,32'h14,32'hB1000014, 1,0,1,   1,0,32'h10,32'hA1000010));
      vt.push_back(mk(0,1,32'h18,32'hC1000018, 1,0,1,   1,0,32'h10,32'hA1000010));
      vt.push_back(mk(0,1,32'h18,32'hC1000018, 1,0,1,   1,0,32'h10,32'hA1000010));
      vt.push_back(mk(0,1,32'h18,32'hC1000018, 0,0,1,   1,1,32'h14,32'hB1000014));
      vt.push_back(mk(0,1,32'h18,32'hC1000018, 0,0,1,   1,1,32'h18,32'hC1000018));
      vt.push_back(mk(0,0,32'h00,32'h0,        0,0,1,   0,1,32'h18,NOP));
      // T4: flush while in SKID with D offered
      vt.push_back(mk(0,1,32'h20,32'hE0000020, 1,0,0,   1,1,32'h20,32'hE0000020));
      vt.push_back(mk(0,1,32'h24,32'hF0000024, 1,0,0,   1,0,32'h20,32'hE0000020));
      vt.push_back(mk(0,1,32'h28,32'hD0000028, 1,1,0,   0,1,RSTPC, NOP));
      vt.push_back(mk(0,0,32'h00,32'h0,        0,0,1,   0,1,RSTPC, NOP));
      // T5: rst together with flush mid-stream, then a single beat
      vt.push_back(mk(0,1,32'h30,32'h60000030, 0,0,0,   1,1,32'h30,32'h60000030));
      vt.push_back(mk(0,1,32'h34,32'h70000034, 1,0,0,   1,0,32'h30,32'h60000030));
      vt.push_back(mk(1,1,32'h38,32'h80000038, 0,1,1,   0,1,RSTPC, NOP));
      vt.push_back(mk(0,1,32'h3C,32'h9000003C, 0,0,1,   1,1,32'h3C,32'h9000003C));
      vt.push_back(mk(0,0,32'h00,32'h0,        0,0,1,   0,1,32'h3C,NOP));

      foreach (vt[i]) begin
         step(vt[i].r, vt[i].iv, vt[i].pc, vt[i].inst, vt[i].st, vt[i].fl, vt[i].ordy);
         cmp($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vt[i].e_valid));
         cmp($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(vt[i].e_ready));
         cmp($sformatf("vec%0d.out_pc", i),    64'(out_pc),    64'(vt[i].e_pc));
         cmp($sformatf("vec%0d.out_inst", i),  64'(out_inst),  64'(vt[i].e_inst));
      end

`ifdef IF_ID_STAGE_STAT_EN
      // T6: five stalled cycles with valid data, then two flushes, then reset
      step(1, 0, 32'h0, 32'h0, 0, 0, 0);
      step(0, 1, 32'h40, 32'h12340040, 0, 0, 0);
      for (int k = 0; k < 5; k++) step(0, 0, 32'h0, 32'h0, 1, 0, 1);
      step(0, 0, 32'h0, 32'h0, 0, 1, 1);
      step(0, 0, 32'h0, 32'h0, 0, 1, 1);
      cmp("t6.stall_cnt", 64'(stall_cnt), 64'd5);
      cmp("t6.flush_cnt", 64'(flush_cnt), 64'd2);
      step(1, 0, 32'h0, 32'h0, 0, 0, 0);
      cmp("t6.stall_cnt_rst", 64'(stall_cnt), 64'd0);
      cmp("t6.flush_cnt_rst", 64'(flush_cnt), 64'd0);
`endif

      // Randomised traffic checked against the FIFO model
      step(1, 0, 32'h0, 32'h0, 0, 0, 0);
      check_model("rnd_init");
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 3) != 0,
              $urandom,
              $urandom,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) != 0);
         check_model($sformatf("rnd%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
